// File: rtl/lsu_wb_master.sv
// Wishbone B4 pipelined master for LSU loads/stores on the TCM data port (port0).
// Handles byte-lane steering, store replication, load extension, misalignment,
// bus errors and timeout. Only one transfer is in flight at a time.
module lsu_wb_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  port0_wb_clk_i,
  input  logic                  port0_wb_rst_i,
  // LSU request
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  // LSU response
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic [1:0]            resp_cause_o,
  // Wishbone master
  output logic                  port0_wb_cyc_o,
  output logic                  port0_wb_stb_o,
  output logic                  port0_wb_we_o,
  output logic [ADDR_WIDTH-1:0] port0_wb_adr_o,
  output logic [31:0]           port0_wb_dat_o,
  output logic [3:0]            port0_wb_sel_o,
  input  logic                  port0_wb_stall_i,
  input  logic                  port0_wb_ack_i,
  input  logic [31:0]           port0_wb_dat_i,
  input  logic                  port0_wb_err_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] CAUSE_OK      = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_RESP = 2'b11
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [1:0]       r_addr_lo;

  logic             w_misaligned;
  logic [3:0]       w_sel;
  logic [31:0]      w_wdata;
  logic [31:0]      w_lane;
  logic [31:0]      w_rdata_ext;
  logic             w_timeout;

  // Misalignment / illegal-size detection on the incoming request
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size_i)
      SZ_BYTE: w_misaligned = 1'b0;
      SZ_HALF: w_misaligned = req_addr_i[0];
      SZ_WORD: w_misaligned = (req_addr_i[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

  // Byte-lane select and replicated write data for the incoming request
  always_comb begin
    w_sel   = 4'b0000;
    w_wdata = 32'h0;
    case (req_size_i)
      SZ_BYTE: begin
        w_sel   = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        w_sel   = req_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata_i[15:0]}};
      end
      default: begin
        w_sel   = 4'b1111;
        w_wdata = req_wdata_i;
      end
    endcase
  end

  // Right-align the addressed lane, then sign/zero extend by latched size
  always_comb begin
    w_lane      = port0_wb_dat_i >> {r_addr_lo, 3'b000};
    w_rdata_ext = w_lane;
    case (r_size)
      SZ_BYTE: w_rdata_ext = r_unsigned ? {24'h0, w_lane[7:0]}
                                        : {{24{w_lane[7]}}, w_lane[7:0]};
      SZ_HALF: w_rdata_ext = r_unsigned ? {16'h0, w_lane[15:0]}
                                        : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_rdata_ext = w_lane;
    endcase
  end

  // Counter holds the number of REQ/WAIT cycles already elapsed
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Transfer FSM with registered bus and response outputs
  always_ff @(posedge port0_wb_clk_i or posedge port0_wb_rst_i) begin
    if (port0_wb_rst_i) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_we           <= 1'b0;
      r_size         <= 2'b00;
      r_unsigned     <= 1'b0;
      r_addr_lo      <= 2'b00;
      req_ready_o    <= 1'b1;
      resp_valid_o   <= 1'b0;
      resp_rdata_o   <= 32'h0;
      resp_cause_o   <= CAUSE_OK;
      port0_wb_cyc_o <= 1'b0;
      port0_wb_stb_o <= 1'b0;
      port0_wb_we_o  <= 1'b0;
      port0_wb_adr_o <= '0;
      port0_wb_dat_o <= 32'h0;
      port0_wb_sel_o <= 4'b0000;
    end else begin
      resp_valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            r_cnt       <= '0;
            r_we        <= req_we_i;
            r_size      <= req_size_i;
            r_unsigned  <= req_unsigned_i;
            r_addr_lo   <= req_addr_i[1:0];
            if (w_misaligned) begin
              r_state      <= S_RESP;
              resp_valid_o <= 1'b1;
              resp_rdata_o <= 32'h0;
              resp_cause_o <= CAUSE_ALIGN;
            end else begin
              r_state        <= S_REQ;
              port0_wb_cyc_o <= 1'b1;
              port0_wb_stb_o <= 1'b1;
              port0_wb_we_o  <= req_we_i;
              port0_wb_adr_o <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
              port0_wb_dat_o <= req_we_i ? w_wdata : 32'h0;
              port0_wb_sel_o <= w_sel;
            end
          end
        end

        S_REQ, S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (port0_wb_err_i || port0_wb_ack_i || w_timeout) begin
            r_state        <= S_RESP;
            port0_wb_cyc_o <= 1'b0;
            port0_wb_stb_o <= 1'b0;
            resp_valid_o   <= 1'b1;
            if (port0_wb_err_i) begin
              resp_cause_o <= CAUSE_BUSERR;
              resp_rdata_o <= 32'h0;
            end else if (port0_wb_ack_i) begin
              resp_cause_o <= CAUSE_OK;
              resp_rdata_o <= r_we ? 32'h0 : w_rdata_ext;
            end else begin
              resp_cause_o <= CAUSE_TIMEOUT;
              resp_rdata_o <= 32'h0;
            end
          end else if ((r_state == S_REQ) && !port0_wb_stall_i) begin
            r_state        <= S_WAIT;
            port0_wb_stb_o <= 1'b0;
          end
        end

        S_RESP: begin
          r_state     <= S_IDLE;
          req_ready_o <= 1'b1;
        end

        default: begin
          r_state     <= S_IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed testbench for lsu_wb_master against a small word-addressed memory slave.
module tb_lsu_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_stall;
  logic        wb_ack;
  logic [31:0] wb_dat_i;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs, written only by the stimulus process
  int unsigned stall_cfg = 0;
  logic        noack_mode = 1'b0;
  logic        err_mode = 1'b0;

  logic [31:0] mem [0:15];
  int unsigned stall_seen;

  always #5 clk = ~clk;

  lsu_wb_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .port0_wb_clk_i   (clk),
    .port0_wb_rst_i   (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_we_i         (req_we),
    .req_size_i       (req_size),
    .req_unsigned_i   (req_uns),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_rdata_o     (resp_rdata),
    .resp_cause_o     (resp_cause),
    .port0_wb_cyc_o   (wb_cyc),
    .port0_wb_stb_o   (wb_stb),
    .port0_wb_we_o    (wb_we),
    .port0_wb_adr_o   (wb_adr),
    .port0_wb_dat_o   (wb_dat_o),
    .port0_wb_sel_o   (wb_sel),
    .port0_wb_stall_i (wb_stall),
    .port0_wb_ack_i   (wb_ack),
    .port0_wb_dat_i   (wb_dat_i),
    .port0_wb_err_i   (wb_err)
  );

  assign wb_stall = (stall_seen < stall_cfg);

  // Pipelined slave: stalls stall_cfg strobe cycles, then acks/errs one cycle later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack     <= 1'b0;
      wb_err     <= 1'b0;
      wb_dat_i   <= 32'h0;
      stall_seen <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h1122_3344;
      mem[4] <= 32'hDEAD_BEEF;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      if (!wb_cyc) stall_seen <= 0;
      else if (wb_stb && wb_stall) stall_seen <= stall_seen + 1;
      if (wb_cyc && wb_stb && !wb_stall) begin
        if (err_mode) wb_err <= 1'b1;
        else if (!noack_mode) begin
          wb_ack   <= 1'b1;
          wb_dat_i <= mem[wb_adr[5:2]];
          if (wb_we)
            for (int b = 0; b < 4; b++)
              if (wb_sel[b]) mem[wb_adr[5:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
        end
      end
    end
  end

  // Issue one request and observe the bus until the response (bounded)
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic got, output logic [31:0] rdata,
                        output logic [1:0] cause, output int lat, output int stb_cyc,
                        output logic cyc_seen, output logic [3:0] sel_seen,
                        output logic [31:0] dat_seen, output logic we_seen,
                        output logic busy_ready);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    got = 1'b0; rdata = 32'h0; cause = 2'b00; lat = 0; stb_cyc = 0;
    cyc_seen = 1'b0; sel_seen = 4'h0; dat_seen = 32'h0; we_seen = 1'b0; busy_ready = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (wb_cyc) cyc_seen = 1'b1;
      if (wb_stb) begin
        stb_cyc++; sel_seen = wb_sel; dat_seen = wb_dat_o; we_seen = wb_we;
      end
      if (req_ready) busy_ready = 1'b1;
      if (resp_valid) begin
        got = 1'b1; rdata = resp_rdata; cause = resp_cause;
        break;
      end
      @(posedge clk);
      lat++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL resp_timeout addr=%h got=no response required=response", addr);
    end
  endtask

  logic        g_got, g_we, g_cyc, g_busy;
  logic [31:0] g_rdata, g_dat;
  logic [1:0]  g_cause;
  logic [3:0]  g_sel;
  int          g_lat, g_stb;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb got=%b%b exp=00", wb_cyc, wb_stb); end
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_cause !== 2'b00) begin
      errors++; $display("FAIL reset_resp got=%b/%h/%b exp=0/0/0", resp_valid, resp_rdata, resp_cause); end
    checks++; if (wb_sel !== 4'h0 || wb_we !== 1'b0 || wb_adr !== 32'h0 || wb_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_bus got sel=%h we=%b adr=%h dat=%h exp=0", wb_sel, wb_we, wb_adr, wb_dat_o); end
  endtask

  task automatic test_load_word();
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
    checks++; if (g_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", g_rdata); end
    checks++; if (g_cause !== 2'b00) begin errors++; $display("FAIL lw_cause got=%b exp=00", g_cause); end
    checks++; if (g_stb !== 1) begin errors++; $display("FAIL lw_stb_cycles got=%0d exp=1", g_stb); end
    checks++; if (g_sel !== 4'b1111 || g_we !== 1'b0) begin errors++; $display("FAIL lw_sel_we got=%b/%b exp=1111/0", g_sel, g_we); end
    checks++; if (g_lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", g_lat); end
    checks++; if (g_busy !== 1'b0) begin errors++; $display("FAIL lw_ready_busy got=%b exp=0", g_busy); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || wb_cyc !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL lw_after got ready=%b cyc=%b rv=%b exp=1/0/0", req_ready, wb_cyc, resp_valid); end
  endtask

  task automatic test_load_extend();
    logic [1:0]  sz  [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic        un  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ad  [4] = '{32'h13, 32'h12, 32'h11, 32'h10};
    logic [31:0] exd [4] = '{32'hFFFF_FFDE, 32'h0000_DEAD, 32'h0000_00BE, 32'hFFFF_BEEF};
    logic [3:0]  exs [4] = '{4'b1000, 4'b1100, 4'b0010, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
      checks++; if (g_rdata !== exd[i]) begin errors++; $display("FAIL ld_ext_%0d got=%h exp=%h", i, g_rdata, exd[i]); end
      checks++; if (g_sel !== exs[i]) begin errors++; $display("FAIL ld_sel_%0d got=%b exp=%b", i, g_sel, exs[i]); end
    end
  endtask

  task automatic test_store();
    do_req(1'b1, 2'b00, 1'b0, 32'h01, 32'hFFFF_FFA5, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
    checks++; if (g_we !== 1'b1 || g_sel !== 4'b0010) begin errors++; $display("FAIL sb_we_sel got=%b/%b exp=1/0010", g_we, g_sel); end
    checks++; if (g_dat !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_dat got=%h exp=a5a5a5a5", g_dat); end
    checks++; if (g_rdata !== 32'h0 || g_cause !== 2'b00) begin errors++; $display("FAIL sb_resp got=%h/%b exp=0/00", g_rdata, g_cause); end
    do_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
    checks++; if (g_rdata !== 32'h1122_A544) begin errors++; $display("FAIL sb_readback got=%h exp=1122a544", g_rdata); end
    do_req(1'b1, 2'b01, 1'b0, 32'h02, 32'h1234_BEEF, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
    checks++; if (g_sel !== 4'b1100 || g_dat !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_sel_dat got=%b/%h exp=1100/beefbeef", g_sel, g_dat); end
    do_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
    checks++; if (g_rdata !== 32'hBEEF_A544) begin errors++; $display("FAIL sh_readback got=%h exp=beefa544", g_rdata); end
  endtask

  task automatic test_misaligned();
    logic        w  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3] = '{32'h02, 32'h03, 32'h00};
    for (int i = 0; i < 3; i++) begin
      do_req(w[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
      checks++; if (g_cause !== 2'b01 || g_rdata !== 32'h0) begin errors++; $display("FAIL mis_resp_%0d got=%b/%h exp=01/0", i, g_cause, g_rdata); end
      checks++; if (g_cyc !== 1'b0) begin errors++; $display("FAIL mis_cyc_%0d got=%b exp=0", i, g_cyc); end
      checks++; if (g_lat !== 0) begin errors++; $display("FAIL mis_latency_%0d got=%0d exp=0", i, g_lat); end
    end
  endtask

  task automatic test_stall();
    stall_cfg = 3;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
    stall_cfg = 0;
    checks++; if (g_stb !== 4) begin errors++; $display("FAIL stall_stb_cycles got=%0d exp=4", g_stb); end
    checks++; if (g_rdata !== 32'hDEAD_BEEF || g_cause !== 2'b00) begin errors++; $display("FAIL stall_resp got=%h/%b exp=deadbeef/00", g_rdata, g_cause); end
    checks++; if (g_lat !== 5) begin errors++; $display("FAIL stall_latency got=%0d exp=5", g_lat); end
  endtask

  task automatic test_timeout_err();
    noack_mode = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
    noack_mode = 1'b0;
    checks++; if (g_cause !== 2'b11 || g_rdata !== 32'h0) begin errors++; $display("FAIL to_resp got=%b/%h exp=11/0", g_cause, g_rdata); end
    checks++; if (g_lat !== 16) begin errors++; $display("FAIL to_latency got=%0d exp=16", g_lat); end
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL to_cyc got=%b exp=0", wb_cyc); end
    err_mode = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
    err_mode = 1'b0;
    checks++; if (g_cause !== 2'b10 || g_rdata !== 32'h0) begin errors++; $display("FAIL err_resp got=%b/%h exp=10/0", g_cause, g_rdata); end
    checks++; if (g_lat !== 2) begin errors++; $display("FAIL err_latency got=%0d exp=2", g_lat); end
  endtask

  task automatic test_reset_mid();
    logic rv_seen;
    noack_mode = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b0) begin errors++; $display("FAIL rmid_wait got cyc=%b stb=%b exp=1/0", wb_cyc, wb_stb); end
    rst = 1'b1;
    #1;
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_async got cyc=%b stb=%b rv=%b exp=000", wb_cyc, wb_stb, resp_valid); end
    noack_mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rv_seen = 1'b1;
    end
    checks++; if (rv_seen !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rmid_after got rv=%b ready=%b exp=0/1", rv_seen, req_ready); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, g_got, g_rdata, g_cause, g_lat, g_stb, g_cyc, g_sel, g_dat, g_we, g_busy);
    checks++; if (g_rdata !== 32'hDEAD_BEEF || g_cause !== 2'b00) begin errors++; $display("FAIL rmid_lw got=%h/%b exp=deadbeef/00", g_rdata, g_cause); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_misaligned();
    test_stall();
    test_timeout_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
